// File: rtl/imem_arbiter_if.sv
// Bus bundle between the IF fetch port, the program loader, the imem array and the arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface imem_arbiter_if #(
    parameter int IMEM_ADDR_WIDTH = 10
);
    logic                       if_req;
    logic [31:0]                if_addr;
    logic                       if_gnt;
    logic                       if_rvalid;
    logic [31:0]                if_rdata;
    logic                       if_stall;

    logic                       ld_req;
    logic                       ld_we;
    logic                       ld_lock;
    logic [31:0]                ld_addr;
    logic [31:0]                ld_wdata;
    logic                       ld_gnt;
    logic                       ld_rvalid;
    logic [31:0]                ld_rdata;

    logic                       mem_en;
    logic                       mem_we;
    logic [IMEM_ADDR_WIDTH-3:0] mem_addr;
    logic [31:0]                mem_wdata;
    logic [31:0]                mem_rdata;

    logic                       misalign_err;

    modport slave (
        input  if_req, if_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_stall,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, misalign_err
    );

    modport master (
        output if_req, if_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_stall,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, misalign_err
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port imem arbiter: strict loader priority, lockable download window, 1-cycle read return.
// Defining IMEM_ARB_FAIRNESS_EN adds a loader-burst limit of MAX_LD_BURST grants while fetch waits.
module imem_arbiter #(
    parameter int IMEM_ADDR_WIDTH = 10
`ifdef IMEM_ARB_FAIRNESS_EN
    ,
    parameter int MAX_LD_BURST    = 4
`endif
) (
    input logic           clk,
    input logic           rst,
    imem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_LOCKED
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        if_gnt_c;
    logic        ld_gnt_c;
    logic        fair_force;
    logic        if_pend;
    logic        ld_pend;
    logic        misalign_q;
    logic [31:0] gnt_addr;
    logic        unused_addr_hi;

`ifdef IMEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_LD_BURST + 1);
    logic [CNT_W-1:0] burst_cnt;

    assign fair_force = (burst_cnt == CNT_W'(MAX_LD_BURST));

    // Saturates so a long locked burst cannot wrap past the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt <= '0;
        end else if (if_gnt_c || !bus.if_req) begin
            burst_cnt <= '0;
        end else if (ld_gnt_c && !fair_force) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end
`else
    assign fair_force = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        if_gnt_c = 1'b0;
        ld_gnt_c = 1'b0;
        state_nx = S_IDLE;
        // Grants are gated by reset so nothing reaches the memory while rst is low.
        if (!rst) begin
            state_nx = S_IDLE;
        end else if (state == S_LOCKED) begin
            ld_gnt_c = bus.ld_req;
            state_nx = bus.ld_lock ? S_LOCKED : S_IDLE;
        end else if (bus.ld_lock) begin
            ld_gnt_c = bus.ld_req;
            state_nx = S_LOCKED;
        end else if (fair_force && bus.if_req) begin
            if_gnt_c = 1'b1;
            state_nx = S_FETCH;
        end else if (bus.ld_req) begin
            ld_gnt_c = 1'b1;
            state_nx = S_LOAD;
        end else if (bus.if_req) begin
            if_gnt_c = 1'b1;
            state_nx = S_FETCH;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            if_pend    <= 1'b0;
            ld_pend    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state   <= state_nx;
            if_pend <= if_gnt_c;
            ld_pend <= ld_gnt_c & ~bus.ld_we;
            if ((if_gnt_c || ld_gnt_c) && (gnt_addr[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    always_comb begin
        gnt_addr = 32'h0;
        if (ld_gnt_c) begin
            gnt_addr = bus.ld_addr;
        end else if (if_gnt_c) begin
            gnt_addr = bus.if_addr;
        end
    end

    // Bits above the decoded range are deliberately dropped so addresses wrap.
    assign unused_addr_hi = ^gnt_addr[31:IMEM_ADDR_WIDTH];

    assign bus.if_gnt       = if_gnt_c;
    assign bus.ld_gnt       = ld_gnt_c;
    assign bus.if_stall     = rst & bus.if_req & ~if_gnt_c;

    assign bus.mem_en       = if_gnt_c | ld_gnt_c;
    assign bus.mem_we       = ld_gnt_c & bus.ld_we;
    assign bus.mem_addr     = gnt_addr[IMEM_ADDR_WIDTH-1:2];
    assign bus.mem_wdata    = ld_gnt_c ? bus.ld_wdata : 32'h0;

    assign bus.if_rvalid    = if_pend;
    assign bus.if_rdata     = if_pend ? bus.mem_rdata : 32'h0;
    assign bus.ld_rvalid    = ld_pend;
    assign bus.ld_rdata     = ld_pend ? bus.mem_rdata : 32'h0;

    assign bus.misalign_err = misalign_q;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the IF-stage fetch port (read-only) and the debug/program loader port (read/write).
- Sits between the pipeline IF stage, the loader, and the Imem storage array.
- Issues one memory access per cycle and returns read data one cycle later to the requester that was granted.
- Stalls fetch while the loader owns the memory, including a locked download window.

Parameters:
- IMEM_ADDR_WIDTH, 10, byte-address bits decoded by the memory (1 KiB default); word index is IMEM_ADDR_WIDTH-2 bits.
- MAX_LD_BURST, 4, maximum consecutive loader grants while fetch is waiting (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid (one cycle after if_gnt).
- if_rdata  out  32  fetch read data.
- if_stall  out  1  IF must hold its PC this cycle.
- ld_req  in  1  loader request.
- ld_we  in  1  1 = write, 0 = read.
- ld_lock  in  1  loader holds exclusive ownership while high.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_gnt  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  ld_rdata valid (reads only, one cycle after ld_gnt).
- ld_rdata  out  32  loader read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  IMEM_ADDR_WIDTH-2  word index = granted addr[IMEM_ADDR_WIDTH-1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, registered inside the memory (valid one cycle after mem_en).
- misalign_err  out  1  sticky flag; set on any granted access with addr[1:0] != 0.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM returns to IDLE; fairness counter = 0; pending-owner register cleared.
  - All outputs are 0, except if_stall = 0 and misalign_err = 0.
  - Any read in flight when reset asserts is dropped: no rvalid is generated after reset releases.
- FSM states:
  - IDLE: no owner.
  - FETCH: the last grant went to IF.
  - LOAD: the last grant went to the loader.
  - LOCKED: the loader owns the memory exclusively.
- Grant logic (combinational from the inputs and the registered state; exactly one grant per cycle at most):
  - LOCKED: only the loader may be granted. Exit to IDLE when ld_lock is sampled low.
  - Otherwise, if ld_lock is high, the loader is granted if ld_req is high, and the state moves to LOCKED.
  - Otherwise, ld_req beats if_req (strict loader priority).
  - IF is granted only when ld_req is low.
- Next state: FETCH if IF was granted, LOAD if the loader was granted (or LOCKED as above), IDLE if no grant.
- Memory drive:
  - mem_en = any grant.
  - mem_we = ld_gnt & ld_we.
  - mem_addr and mem_wdata are taken from the granted requester.
  - When idle, mem_addr and mem_wdata are 0.
- Read return:
  - The owner of each granted read is registered.
  - Next cycle, the matching rvalid pulses for one cycle and the corresponding rdata = mem_rdata.
  - Outside an rvalid pulse, the rdata outputs are 0.
  - A loader write produces no ld_rvalid.
- if_stall = if_req & ~if_gnt. When if_req is low, if_stall is 0.
- Address handling:
  - Bits above IMEM_ADDR_WIDTH-1 are ignored, so addresses wrap modulo the memory size.
  - Misaligned accesses still proceed with addr[1:0] dropped; misalign_err sets and is cleared only by reset.
- Simultaneous events:
  - if_req and ld_req high in the same cycle: the loader wins and IF stalls.
  - ld_lock rising in the same cycle as an IF grant is not possible, because the loader always wins when ld_req is high.
  - ld_lock high without ld_req: no grant, but IF is still blocked and the state enters LOCKED.
- Latency: grant in cycle N, data in cycle N+1. Back-to-back grants are allowed every cycle.

Optional Feature:
- Macro: IMEM_ARB_FAIRNESS_EN.
- With the macro:
  - A counter increments on every loader grant issued while if_req is high.
  - It resets to 0 on any IF grant or whenever if_req is low.
  - When the counter equals MAX_LD_BURST and the state is not LOCKED, IF is granted that cycle regardless of ld_req.
- Without the macro: strict loader priority; the counter logic is absent.
- ld_lock always overrides fairness, with or without the macro.

Test Plan:
- Reset then if_req=1, if_addr=0x8 for 3 cycles -> if_gnt=1 each cycle, mem_addr=2; if_rvalid from cycle 2 with if_rdata = mem word[2]; if_stall=0.
- ld_req=1, ld_we=1, ld_addr=0x10, ld_wdata=0xDEADBEEF together with if_req=1 -> ld_gnt=1, mem_we=1, mem_addr=4, if_stall=1. Next cycle the IF read of 0x10 returns 0xDEADBEEF.
- ld_lock=1 with 3 loader writes, then ld_req=0 while ld_lock=1 and if_req=1 -> if_gnt=0, if_stall=1. After ld_lock drops -> if_gnt in the following cycle.
- With IMEM_ARB_FAIRNESS_EN, MAX_LD_BURST=4, ld_req and if_req held high -> grant pattern L,L,L,L,F repeating. Without the macro -> L continuously and if_stall stays 1.
- Granted ld_addr=0x6 -> mem_addr=1 and misalign_err=1, which stays 1 until rst is asserted.
- rst asserted in the cycle after if_gnt -> no if_rvalid afterwards; all outputs 0 during and after reset.
